// File: rtl/mmuart_fabric_rx_pkg.sv
// Shared constants and FSM state type for the fabric-side MMUART receiver.
package mmuart_rx_pkg;

  // Oversample ticks per bit, tick index of the start-bit centre, payload size.
  localparam int OVS_RATE  = 16;
  localparam int MID_TICK  = 8;
  localparam int DATA_BITS = 8;

  // Deserializer states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/mmuart_fabric_rx_if.sv
// Byte-stream side of the receiver: valid/ready data plus error flags.
// The receiver is the master (it produces bytes); the consumer is the slave.
interface mmuart_fabric_rx_if;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic       ERR_CLR;

  modport master (
    output RX_DATA,
    output RX_VALID,
    output FRAME_ERR,
    output OVERRUN,
    input  RX_READY,
    input  ERR_CLR
  );

  modport slave (
    input  RX_DATA,
    input  RX_VALID,
    input  FRAME_ERR,
    input  OVERRUN,
    output RX_READY,
    output ERR_CLR
  );
endinterface

// File: rtl/mmuart_fabric_rx_fifo.sv
// Small show-ahead FIFO: dout_o always presents the oldest entry.
// A push while full is accepted only when a pop happens in the same cycle.
module mmuart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage entries, cleared on reset so the head reads 0x00 out of reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          mem_q[gi] <= '0;
        end else if (do_push && (wr_ptr_q == AW'(gi))) begin
          mem_q[gi] <= din_i;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mmuart_fabric_rx.sv
// Fabric-side 8N1 UART receiver for the MSS MMUART TXD line.
// RXD -> 2-FF synchronizer -> 16x oversampling deserializer -> show-ahead FIFO.
module mmuart_fabric_rx
  import mmuart_rx_pkg::*;
#(
  parameter int OVS_DIV    = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               RXD,
  mmuart_fabric_rx_if.master rx
);

  localparam int DIV_W = $clog2(OVS_DIV);
  localparam int SUB_W = $clog2(OVS_RATE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OVS_DIV - 1);
  localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(MID_TICK - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVS_RATE - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  logic             sync1_q, rxd_s_q;
  rx_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             tick, push, pop;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;

  assign tick = (div_cnt_q == DIV_LAST);
  assign pop  = ~fifo_empty & rx.RX_READY;

  assign rx.RX_DATA   = fifo_dout;
  assign rx.RX_VALID  = ~fifo_empty;
  assign rx.FRAME_ERR = frame_err_q;
  assign rx.OVERRUN   = overrun_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      sync1_q <= RXD;
      rxd_s_q <= sync1_q;
    end
  end

  // Deserializer state, oversample counters, shift register and error pulse.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      sub_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      sub_cnt_q   <= sub_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic. Counters are held at zero in IDLE, so the first tick
  // after a start edge always lands OVS_DIV cycles later.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    sub_cnt_d   = tick ? sub_cnt_q + 1'b1 : sub_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;

    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        sub_cnt_d = '0;
        bit_idx_d = '0;
        if (!rxd_s_q) state_d = START;
      end

      START: begin
        // Mid start bit: a high line here means the edge was a glitch.
        if (tick && (sub_cnt_q == SUB_MID)) begin
          sub_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rxd_s_q ? IDLE : DATA;
        end
      end

      DATA: begin
        if (tick && (sub_cnt_q == SUB_LAST)) begin
          sub_cnt_d = '0;
          shift_d   = {rxd_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == BIT_LAST) state_d = STOP;
        end
      end

      STOP: begin
        if (tick && (sub_cnt_q == SUB_LAST)) begin
          sub_cnt_d = '0;
          if (rxd_s_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        // A held-low line (break) must return high before the next frame.
        if (rxd_s_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Overrun: a good byte with nowhere to go sets the flag; set beats clear.
  always_comb begin
    overrun_d = overrun_q;
    if (push && fifo_full && !pop) begin
      overrun_d = 1'b1;
    end else if (rx.ERR_CLR) begin
      overrun_d = 1'b0;
    end
  end

  // Sticky overrun flag register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end

  mmuart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .push_i  (push),
    .din_i   (shift_q),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_mmuart_fabric_rx.sv
// Directed bench for mmuart_fabric_rx with OVS_DIV=4 (64 CLK per bit).
module tb_mmuart_fabric_rx;

  localparam int OVS_DIV = 4;
  localparam int BIT     = 16 * OVS_DIV;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  logic RXD   = 1'b1;

  mmuart_fabric_rx_if rx_if ();

  mmuart_fabric_rx #(
    .OVS_DIV    (OVS_DIV),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .RXD   (RXD),
    .rx    (rx_if.master)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_q [$];
  int         fe_cnt = 0;

  // Record every accepted byte and every FRAME_ERR cycle, sampled mid-cycle.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (rx_if.RX_VALID && rx_if.RX_READY) begin
        rx_q.push_back(rx_if.RX_DATA);
        $display("rx byte 0x%02h at %0t", rx_if.RX_DATA, $time);
      end
      if (rx_if.FRAME_ERR) fe_cnt++;
    end
  end

  // Advance n clocks; inputs change 2 time units after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    RXD = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      RXD = d[i];
      tick(BIT);
    end
    RXD = stop_bit;
    tick(BIT);
    RXD = 1'b1;
  endtask

  task automatic clear_log();
    rx_q.delete();
    fe_cnt = 0;
  endtask

  task automatic test_reset();
    rx_if.RX_READY = 1'b0;
    rx_if.ERR_CLR  = 1'b0;
    tick(3);
    checks++; if (rx_if.RX_DATA !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", rx_if.RX_DATA); end
    checks++; if (rx_if.RX_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_if.RX_VALID); end
    checks++; if (rx_if.FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", rx_if.FRAME_ERR); end
    checks++; if (rx_if.OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", rx_if.OVERRUN); end
    RESET = 1'b0;
    tick(20);
    checks++; if (rx_if.RX_VALID !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", rx_if.RX_VALID); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    clear_log();
    rx_if.RX_READY = 1'b1;
    send_byte(8'hA5, 1'b1);
    tick(20);
    checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d bytes expected 1", rx_q.size()); end
    checks++; if (rx_q.size() == 0 || rx_q[0] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %02h expected a5", (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL basic_frame_err: got %0d pulses expected 0", fe_cnt); end
    checks++; if (rx_if.OVERRUN !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b expected 0", rx_if.OVERRUN); end
    $display("test_basic done");
  endtask

  task automatic test_glitch();
    clear_log();
    rx_if.RX_READY = 1'b1;
    RXD = 1'b0;
    tick(20);
    RXD = 1'b1;
    tick(100);
    checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL glitch_count: got %0d bytes expected 0", rx_q.size()); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL glitch_frame_err: got %0d pulses expected 0", fe_cnt); end
    send_byte(8'h3C, 1'b1);
    tick(20);
    checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL after_glitch_count: got %0d bytes expected 1", rx_q.size()); end
    checks++; if (rx_q.size() == 0 || rx_q[0] !== 8'h3C) begin errors++; $display("FAIL after_glitch_data: got %02h expected 3c", (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
    $display("test_glitch done");
  endtask

  task automatic test_frame_err();
    clear_log();
    rx_if.RX_READY = 1'b1;
    send_byte(8'h55, 1'b0);
    tick(100);
    checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL frame_err_cycles: got %0d expected 1", fe_cnt); end
    checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL frame_err_count: got %0d bytes expected 0", rx_q.size()); end
    clear_log();
    RXD = 1'b0;
    tick(2000);
    RXD = 1'b1;
    tick(100);
    checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL break_cycles: got %0d expected 1", fe_cnt); end
    checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL break_count: got %0d bytes expected 0", rx_q.size()); end
    $display("test_frame_err done");
  endtask

  task automatic test_overrun();
    logic [7:0] exp_b [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    clear_log();
    rx_if.RX_READY = 1'b0;
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    checks++; if (rx_if.OVERRUN !== 1'b0) begin errors++; $display("FAIL overrun_early: got %b expected 0", rx_if.OVERRUN); end
    send_byte(8'h05, 1'b1);
    checks++; if (rx_if.OVERRUN !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", rx_if.OVERRUN); end
    rx_if.RX_READY = 1'b1;
    tick(10);
    checks++; if (rx_q.size() !== 4) begin errors++; $display("FAIL overrun_count: got %0d bytes expected 4", rx_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL overrun_data[%0d]: got %02h expected %02h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_b[i]);
      end
    end
    checks++; if (rx_if.RX_VALID !== 1'b0) begin errors++; $display("FAIL overrun_drained: got %b expected 0", rx_if.RX_VALID); end
    rx_if.ERR_CLR = 1'b1;
    tick(1);
    rx_if.ERR_CLR = 1'b0;
    tick(1);
    checks++; if (rx_if.OVERRUN !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", rx_if.OVERRUN); end
    $display("test_overrun done");
  endtask

  task automatic test_pop_on_push();
    logic [7:0] exp_b [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h77};
    clear_log();
    rx_if.RX_READY = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1);
    // Stop sample edge is 611 clocks after the start edge is driven:
    // 2 sync + 1 detect + 8*4 to mid start + 9*64 to mid stop.
    fork
      send_byte(8'h77, 1'b1);
      begin
        tick(610);
        rx_if.RX_READY = 1'b1;
        tick(1);
        rx_if.RX_READY = 1'b0;
      end
    join
    checks++; if (rx_if.OVERRUN !== 1'b0) begin errors++; $display("FAIL pop_on_push_overrun: got %b expected 0", rx_if.OVERRUN); end
    rx_if.RX_READY = 1'b1;
    tick(10);
    checks++; if (rx_q.size() !== 5) begin errors++; $display("FAIL pop_on_push_count: got %0d bytes expected 5", rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL pop_on_push_data[%0d]: got %02h expected %02h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_b[i]);
      end
    end
    $display("test_pop_on_push done");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] part = 8'hC3;
    clear_log();
    rx_if.RX_READY = 1'b0;
    send_byte(8'h3C, 1'b1);
    tick(5);
    checks++; if (rx_if.RX_VALID !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", rx_if.RX_VALID); end
    checks++; if (rx_if.RX_DATA !== 8'h3C) begin errors++; $display("FAIL pre_reset_data: got %02h expected 3c", rx_if.RX_DATA); end
    RXD = 1'b0;
    tick(BIT);
    for (int i = 0; i < 4; i++) begin
      RXD = part[i];
      tick(BIT);
    end
    RXD = part[4];
    tick(BIT / 2);
    RESET = 1'b1;
    #1;
    checks++; if (rx_if.RX_DATA !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got %02h expected 00", rx_if.RX_DATA); end
    checks++; if (rx_if.RX_VALID !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", rx_if.RX_VALID); end
    checks++; if (rx_if.FRAME_ERR !== 1'b0) begin errors++; $display("FAIL mid_reset_frame_err: got %b expected 0", rx_if.FRAME_ERR); end
    checks++; if (rx_if.OVERRUN !== 1'b0) begin errors++; $display("FAIL mid_reset_overrun: got %b expected 0", rx_if.OVERRUN); end
    RXD = 1'b1;
    tick(5);
    RESET = 1'b0;
    tick(20);
    checks++; if (rx_if.RX_VALID !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", rx_if.RX_VALID); end
    rx_if.RX_READY = 1'b1;
    send_byte(8'hC3, 1'b1);
    tick(20);
    checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL post_reset_count: got %0d bytes expected 1", rx_q.size()); end
    checks++; if (rx_q.size() == 0 || rx_q[0] !== 8'hC3) begin errors++; $display("FAIL post_reset_data: got %02h expected c3", (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL post_reset_frame_err: got %0d pulses expected 0", fe_cnt); end
    $display("test_reset_mid_frame done");
  endtask

  initial begin
    rx_if.RX_READY = 1'b0;
    rx_if.ERR_CLR  = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_pop_on_push();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
